// File: rtl/bht_predictor.sv
`timescale 1ns/1ps
// Branch history table of saturating counters; 1-cycle registered prediction, one request and one result per cycle.
// Defining PREDICTOR_GSHARE_EN XORs a global history register into the index; ready stays low during the post-reset init sweep.
module bht_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_BITS   = 2,
    parameter int PC_BITS    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  request,
    input  logic [PC_BITS-1:0]    req_pc,
    output logic                  prediction,
    output logic                  pred_valid,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  result,
    input  logic [INDEX_BITS-1:0] res_index,
    input  logic                  taken,
    output logic                  ready
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CNT_BITS-1:0]   INIT_VAL = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]   CNT_MAX  = '1;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state, state_nxt;
    logic [INDEX_BITS-1:0] sweep_ptr;
    logic [CNT_BITS-1:0]   bht_tab [ENTRIES];
    logic [INDEX_BITS-1:0] idx;
    logic [CNT_BITS-1:0]   cnt_cur, cnt_nxt;
    logic                  sweep_done;
    logic                  do_req, do_res;
    logic                  unused_pc;

    // Only the index bits of the PC matter; the rest is consumed here to keep lint quiet.
    assign unused_pc = ^req_pc;

    // Operation is gated on the registered ready so nothing is accepted before the table is whole.
    assign do_req = request & ready;
    assign do_res = result & ready;

`ifdef PREDICTOR_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr, ghr_nxt;

    if (INDEX_BITS == 1) begin : g_ghr_one
        assign ghr_nxt = taken;
    end else begin : g_ghr_shift
        assign ghr_nxt = {ghr[INDEX_BITS-2:0], taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (do_res) begin
            ghr <= ghr_nxt;
        end
    end

    assign idx = req_pc[INDEX_BITS+1:2] ^ ghr;
`else
    assign idx = req_pc[INDEX_BITS+1:2];
`endif

    always_comb begin
        state_nxt  = state;
        sweep_done = (state == INIT) && (sweep_ptr == LAST_IDX);
        case (state)
            INIT:    if (sweep_done) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        cnt_cur = bht_tab[res_index];
        cnt_nxt = cnt_cur;
        if (taken && (cnt_cur != CNT_MAX)) begin
            cnt_nxt = cnt_cur + CNT_BITS'(1);
        end else if (!taken && (cnt_cur != '0)) begin
            cnt_nxt = cnt_cur - CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            sweep_ptr  <= '0;
            ready      <= 1'b0;
            prediction <= 1'b0;
            pred_valid <= 1'b0;
            pred_index <= '0;
        end else begin
            state      <= state_nxt;
            ready      <= (state == RUN);
            pred_valid <= do_req;
            if (state == INIT) begin
                sweep_ptr <= sweep_ptr + INDEX_BITS'(1);
            end
            // Reads the pre-update counter, so a same-cycle result on this entry is not visible yet.
            if (do_req) begin
                prediction <= bht_tab[idx][CNT_BITS-1];
                pred_index <= idx;
            end
        end
    end

    // Table storage needs no reset: the sweep rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            bht_tab[sweep_ptr] <= INIT_VAL;
        end else if (do_res) begin
            bht_tab[res_index] <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for bht_predictor (INDEX_BITS=4, CNT_BITS=2) against an array-of-counters model.
module tb_bht_predictor;
    localparam int IB = 4;
    localparam int CB = 2;
    localparam int PB = 32;
    localparam int N  = 1 << IB;
    localparam int CMAX = (1 << CB) - 1;
    localparam int THR  = 1 << (CB - 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          request = 1'b0;
    logic [PB-1:0] req_pc = '0;
    logic          result = 1'b0;
    logic [IB-1:0] res_index = '0;
    logic          taken = 1'b0;
    logic          prediction, pred_valid, ready;
    logic [IB-1:0] pred_index;

    always #5 clk = ~clk;

    bht_predictor #(.INDEX_BITS(IB), .CNT_BITS(CB), .PC_BITS(PB)) dut (
        .clk(clk), .rst_n(rst_n), .request(request), .req_pc(req_pc),
        .prediction(prediction), .pred_valid(pred_valid), .pred_index(pred_index),
        .result(result), .res_index(res_index), .taken(taken), .ready(ready)
    );

    typedef struct packed {
        logic          p;
        logic [IB-1:0] idx;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   mtab[N];
    int   mghr = 0;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int model_idx(logic [31:0] pc);
        int i;
        i = int'(pc / 4) % N;
`ifdef PREDICTOR_GSHARE_EN
        i = i ^ mghr;
`endif
        return i;
    endfunction

    // One stimulus cycle: inputs set at the negedge, expectation queued, model trained.
    task automatic drive(bit rq, logic [31:0] pc, bit rs, int ri, bit tk);
        exp_t e;
        int   i;
        @(negedge clk);
        request   = rq;
        req_pc    = pc;
        result    = rs;
        res_index = ri[IB-1:0];
        taken     = tk;
        if (rq) begin
            i     = model_idx(pc);
            e.p   = (mtab[i] >= THR);
            e.idx = i[IB-1:0];
            expq.push_back(e);
        end
        if (rs) begin
            if (tk) mtab[ri] = (mtab[ri] < CMAX) ? mtab[ri] + 1 : CMAX;
            else    mtab[ri] = (mtab[ri] > 0) ? mtab[ri] - 1 : 0;
            mghr = ((mghr << 1) | int'(tk)) % N;
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(0, '0, 0, 0, 0);
    endtask

    // Reset, then hold request/result high through the sweep; abort_at>0 stops early for a mid-sweep re-reset.
    task automatic do_reset(int abort_at);
        @(negedge clk);
        rst_n   = 1'b0;
        request = 1'b0;
        result  = 1'b0;
        #1;
        check("rst_prediction", int'(prediction), 0);
        check("rst_pred_valid", int'(pred_valid), 0);
        check("rst_pred_index", int'(pred_index), 0);
        check("rst_ready", int'(ready), 0);
        expq.delete();
        for (int i = 0; i < N; i++) mtab[i] = THR - 1;
        mghr = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        request   = 1'b1;
        req_pc    = $urandom;
        result    = 1'b1;
        res_index = IB'($urandom_range(0, N - 1));
        taken     = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk);
            #1;
            check("init_ready", int'(ready), (k >= N + 1) ? 1 : 0);
            check("init_pred_valid", int'(pred_valid), 0);
            if (abort_at > 0 && k == abort_at) break;
        end
        request = 1'b0;
        result  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pred_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pred actual=valid required=none at %0t", $time);
            end else begin
                e = expq.pop_front();
                check("pred_index", int'(pred_index), int'(e.idx));
                check("prediction", int'(prediction), int'(e.p));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        do_reset(6);
        idle(1);
        do_reset(0);

        for (int i = 0; i < N; i++) drive(1, 32'(i * 4), 0, 0, 0);
        idle(2);

        // Saturate up on entry 5 then walk back down.
        for (int k = 0; k < 4; k++) drive(0, '0, 1, 5, 1);
        drive(1, 32'h14, 1, 5, 0);
        drive(1, 32'h14, 1, 5, 0);
        drive(1, 32'h14, 0, 0, 0);

        // Saturate down on entry 3.
        for (int k = 0; k < 3; k++) drive(0, '0, 1, 3, 0);
        drive(1, 32'h0C, 1, 3, 1);
        drive(1, 32'h0C, 0, 0, 0);

        // Same-cycle request and result on entry 7.
        drive(1, 32'h1C, 1, 7, 1);
        drive(1, 32'h1C, 0, 0, 0);

        // Aliasing and isolation.
        idle(1);
        do_reset(0);
        drive(0, '0, 1, 5, 1);
        drive(0, '0, 1, 5, 1);
        drive(1, 32'h54, 0, 0, 0);
        drive(1, 32'h18, 0, 0, 0);

        // History-dependent index after two taken results.
        idle(1);
        do_reset(0);
        drive(0, '0, 1, 0, 1);
        drive(0, '0, 1, 0, 1);
        drive(1, 32'h14, 0, 0, 0);
        drive(1, 32'h114, 1, 2, 0);

        for (int n = 0; n < 600; n++) begin
            int ri;
            ri = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, N - 1);
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ri,
                  1'($urandom_range(0, 2) != 0));
        end
        idle(3);
        check("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bht_predictor.md
# bht_predictor

Parametrised branch history table: 2^INDEX_BITS saturating counters of CNT_BITS each, indexed by word-aligned PC bits. The predictor returns a registered taken/not-taken prediction one cycle after a request, and trains the addressed counter on each resolved branch. An init sweep loads every entry with the weakly-not-taken value after reset. It replaces the single 2-bit counter predictor in the fetch path and adds an optional gshare index mode.

## Interface
- INDEX_BITS, 6, log2 of table entries (ENTRIES = 2^INDEX_BITS); range 1..12
- CNT_BITS, 2, counter width; range 2..4
- PC_BITS, 32, request PC width; must be at least INDEX_BITS+2

- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- request  in  1  prediction request this cycle
- req_pc  in  PC_BITS  PC of the branch being predicted
- prediction  out  1  predicted direction (1 = taken), registered
- pred_valid  out  1  one-cycle strobe: prediction/pred_index valid
- pred_index  out  INDEX_BITS  table index used for this prediction
- result  in  1  a branch has resolved this cycle
- res_index  in  INDEX_BITS  index to train (the pred_index returned for that branch)
- taken  in  1  resolved direction, qualified by result
- ready  out  1  table initialised, accepting requests and results

## Operation
- FSM states: INIT, RUN.
- INIT: sweep pointer walks 0..ENTRIES-1, one entry per cycle, writing INIT_VAL = 2^(CNT_BITS-1)-1 (weakly not taken). ready=0. Requests are ignored (pred_valid stays 0). Results are dropped, and GHR is not updated.
- INIT -> RUN on the cycle the pointer writes ENTRIES-1. ready=1 from the next cycle onward.
- Index: idx = req_pc[INDEX_BITS+1:2] (XOR GHR in gshare mode, see Configuration).
- Prediction: prediction <= table[idx][CNT_BITS-1], pred_index <= idx, pred_valid <= 1.
- With no request in RUN: pred_valid <= 0; prediction and pred_index hold their last value.
- Training, when result=1 in RUN:
  - taken=1: counter increments, saturating at 2^CNT_BITS-1.
  - taken=0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
- Simultaneous request and result to the same index: the prediction uses the pre-update counter value (read-before-write). The update still lands.
- Different entries are fully independent. PCs equal in bits [INDEX_BITS+1:2] alias to the same entry by design.

## Timing
- Request in cycle t -> prediction, pred_valid and pred_index valid in cycle t+1. Latency is 1; a new request is accepted every cycle.
- Result in cycle t -> counter updated at the edge ending t. Requests from t+1 see the new value.
- Reset values:
  - prediction=0, pred_valid=0, pred_index=0, ready=0
  - FSM=INIT, sweep pointer=0, GHR=0
- Reset asserted mid-operation: outputs go to reset values immediately. The sweep restarts from entry 0 after deassertion, and table contents are reinitialised.
- After rst_n deasserts, ready rises exactly ENTRIES+1 clock edges later.

## Configuration
- PREDICTOR_GSHARE_EN defined:
  - An INDEX_BITS-wide global history register (GHR) is compiled in.
  - idx = req_pc[INDEX_BITS+1:2] ^ GHR.
  - On each result in RUN: GHR <= {GHR[INDEX_BITS-2:0], taken}.
  - A request in the same cycle as a result uses the old GHR.
  - GHR resets to 0 and is not cleared by the sweep.
- PREDICTOR_GSHARE_EN not defined:
  - No GHR.
  - idx = req_pc[INDEX_BITS+1:2].
- Ports are identical in both builds.

## Test plan
Benches use INDEX_BITS=4, CNT_BITS=2 unless noted.
- Reset/init: release rst_n, hold request=1 -> pred_valid=0 and ready=0 for 16 cycles, ready=1 on the 17th edge. All 16 entries then predict 0. Repeat with rst_n pulsed mid-sweep -> full 16-cycle sweep restarts.
- Saturate up: 4 results taken=1 on res_index=5, then request req_pc=0x14 -> pred_index=5, prediction=1. One not-taken -> still 1 (counter 2). A second not-taken -> 0.
- Saturate down: from init, 3 results taken=0 on index 3 -> counter stays 0, prediction 0. Then one taken -> counter 1, prediction still 0.
- Same-cycle hazard: index 7 at counter 1; request req_pc=0x1C together with result taken=1 on index 7 -> prediction=0 (old value). The next request -> 1.
- Aliasing/isolation: train req_pc=0x14 to taken. Request 0x54 -> pred_index=5, prediction=1. Request 0x18 -> pred_index=6, prediction=0.
- PREDICTOR_GSHARE_EN: two results taken=1 (GHR=4'b0011), then request req_pc=0x14 -> pred_index=6. The same request without the macro -> pred_index=5.
